// File: rtl/mem_access_arbiter.sv
// Three-requester round-robin arbiter in front of one memory interface (IDLE/ISSUE/WAIT/DONE).
// Define MEM_ARB_TIMEOUT_EN to compile in a 31-cycle watchdog on the WAIT state.
module mem_access_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] req_rw,
  input  logic [7:0] req_adr0,
  input  logic [7:0] req_adr1,
  input  logic [7:0] req_adr2,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  input  logic [7:0] req_wdata2,
  output logic [2:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       mif_start,
  output logic       mif_readWrite,
  output logic [7:0] mif_adr,
  output logic [7:0] mif_wdata,
  input  logic       mif_finish,
  input  logic [7:0] mif_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] pick_s;
  logic       start_q, start_d;
  logic       rw_q, rw_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       sel_rw_s;
  logic [7:0] sel_adr_s, sel_wdata_s;
  logic       timeout_s;

  // Search starts one past the last winner and wraps modulo 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = last;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (r[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req, last_q);

  always_comb begin
    sel_rw_s    = req_rw[0];
    sel_adr_s   = req_adr0;
    sel_wdata_s = req_wdata0;
    case (pick_s)
      2'd1: begin
        sel_rw_s    = req_rw[1];
        sel_adr_s   = req_adr1;
        sel_wdata_s = req_wdata1;
      end
      2'd2: begin
        sel_rw_s    = req_rw[2];
        sel_adr_s   = req_adr2;
        sel_wdata_s = req_wdata2;
      end
      default: begin
        sel_rw_s    = req_rw[0];
        sel_adr_s   = req_adr0;
        sel_wdata_s = req_wdata0;
      end
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [4:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 5'd1;
    end else begin
      tmo_cnt_d = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= 5'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Counter steps to 31 on this edge, so DONE lands 32 cycles after the start pulse.
  assign timeout_s = (tmo_cnt_q == 5'd30);
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd2;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      adr_q   <= 8'h00;
      wdata_q <= 8'h00;
      done_q  <= 3'b000;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mif_finish || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    start_d = 1'b0;
    rw_d    = rw_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    done_d  = 3'b000;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = pick_s;
          last_d  = pick_s;
          start_d = 1'b1;
          rw_d    = sel_rw_s;
          adr_d   = sel_adr_s;
          wdata_d = sel_wdata_s;
        end else begin
          start_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // A finish arriving on the timeout cycle still counts as a normal completion.
        if (mif_finish) begin
          rdata_d = mif_rdata;
          done_d  = 3'b001 << grant_q;
        end else if (timeout_s) begin
          rdata_d = 8'h00;
          done_d  = 3'b001 << grant_q;
          err_d   = 1'b1;
        end else begin
          done_d  = 3'b000;
        end
      end
      default: begin
        done_d = 3'b000;
      end
    endcase
  end

  assign mif_start     = start_q;
  assign mif_readWrite = rw_q;
  assign mif_adr       = adr_q;
  assign mif_wdata     = wdata_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign err           = err_q;

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req[2:0]  in  3  per-requester access request, level.
REQ-004 SHALL have ports: req_rw[2:0]  in  3  per-requester op, 0 = read, 1 = write.
REQ-005 SHALL have ports: req_adr0/1/2  in  8 each  per-requester address.
REQ-006 SHALL have ports: req_wdata0/1/2  in  8 each  per-requester write data.
REQ-007 SHALL have ports: done[2:0]  out  3  one-hot, one-cycle completion pulse.
REQ-008 SHALL have ports: rdata  out  8  read data, valid while done is high.
REQ-009 SHALL have ports: err  out  1  timeout flag, pulses with done.
REQ-010 SHALL have ports: mif_start  out  1  start to memory interface.
REQ-011 SHALL have ports: mif_readWrite  out  1  op to memory interface.
REQ-012 SHALL have ports: mif_adr  out  8  address to memory interface.
REQ-013 SHALL have ports: mif_wdata  out  8  write data to memory interface.
REQ-014 SHALL have ports: mif_finish  in  1  completion from memory interface.
REQ-015 SHALL have ports: mif_rdata  in  8  read data from memory interface.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; every output SHALL be registered.
REQ-017 IDLE: if any req bit is high, SHALL grant exactly one requester by round-robin, latch its rw/adr/wdata into mif_readWrite/mif_adr/mif_wdata, store the grant index, and go to ISSUE; else SHALL stay in IDLE.
REQ-018 Round-robin order SHALL start at (last_grant+1) mod 3; last_grant SHALL update on every grant.
REQ-019 ISSUE: mif_start SHALL be high for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-020 mif_adr, mif_wdata and mif_readWrite SHALL remain stable from ISSUE through DONE.
REQ-021 WAIT: on mif_finish=1, SHALL capture mif_rdata into rdata and go to DONE; otherwise SHALL stay in WAIT.
REQ-022 DONE: done[grant] SHALL be high for exactly one cycle; all other done bits SHALL be 0; the FSM SHALL then go to IDLE.
REQ-023 For a write, rdata SHALL still be loaded from mif_rdata at finish; its value is don't-care.
REQ-024 A requester SHALL hold req and its inputs stable until its done pulse; inputs of non-granted requesters SHALL be ignored.
REQ-025 If req is still high in IDLE after a done, it SHALL be treated as a new request.
REQ-026 Latency from req sampled in IDLE to done SHALL be 3 + (cycles in WAIT); with the memory interface's 5-cycle finish, this is 8 cycles.
REQ-027 Requests raised during ISSUE, WAIT or DONE SHALL wait for the next IDLE; no request SHALL be dropped.
REQ-028 mif_finish outside WAIT SHALL be ignored.
REQ-029 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-030 On reset, state SHALL be IDLE and last_grant SHALL be 2, so requester 0 wins first.
REQ-031 On reset, mif_start, mif_readWrite, mif_adr, mif_wdata, done, rdata and err SHALL be 0.
REQ-032 Reset mid-transaction SHALL abort it with no done pulse.

Configuration
REQ-033 The timeout SHALL be compiled in by the macro MEM_ARB_TIMEOUT_EN.
REQ-034 With MEM_ARB_TIMEOUT_EN defined, a 5-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-035 With MEM_ARB_TIMEOUT_EN defined, if the counter reaches 31 without mif_finish, the FSM SHALL go to DONE with rdata=0 and err=1 for the one done cycle.
REQ-036 With MEM_ARB_TIMEOUT_EN defined, if finish and timeout occur in the same cycle, finish SHALL win and err SHALL be 0.
REQ-037 Without MEM_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-038 Single read: req=001, rw0=0, adr0=0x3C, memory model returns 0xA5 with finish 5 cycles after start -> one mif_start pulse with mif_adr=0x3C, then done=001 with rdata=0xA5, 8 cycles after the req.
REQ-039 Single write: req=010, rw1=1, adr1=0x10, wdata1=0x77 -> mif_readWrite=1, mif_adr=0x10, mif_wdata=0x77 stable until DONE, then done=010.
REQ-040 Contention after reset: req=111 held -> grants in order 0, 1, 2, 0, each with exactly one done pulse and no overlapping mif_start.
REQ-041 Late arrival: req1 raised during requester 0's WAIT -> requester 1 is issued right after requester 0's DONE; requester 0's transaction is not disturbed.
REQ-042 Reset mid-WAIT: assert reset 2 cycles after mif_start -> all outputs 0, no done pulse; next req=100 is granted normally.
REQ-043 Timeout (MEM_ARB_TIMEOUT_EN defined): memory model never finishes -> done and err high together 32 cycles after mif_start, rdata=0; without the macro -> no done after 100 cycles.
